// File: rtl/decode_arbiter.sv
// Two-channel arbiter feeding a nibble decoder (each nibble stored as value+1 mod 16).
// Define DECODE_ARBITER_ERRCNT_EN to count accepted 0x0 nibbles in a saturating err_cnt.
module decode_arbiter #(
  parameter int FAIR = 1,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [7:0]      req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [7:0]      req1_data,
  output logic            req1_ready,
  output logic            out_valid,
  output logic [7:0]      out_data,
  output logic            out_chan,
  input  logic            out_ready,
  output logic            busy,
  output logic [ERRW-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DECODE, OUTPUT} state_t;

  state_t     state, next_state;
  logic [7:0] cap_data;
  logic       cap_chan;
  logic       last_chan;
  logic       grant_chan;
  logic       accept;
  logic [7:0] grant_data;

  // Grant: alternate on contention when FAIR, otherwise channel 0 always first.
  always_comb begin
    grant_chan = 1'b0;
    if ((FAIR != 0) && req0_valid && req1_valid) grant_chan = ~last_chan;
    else if (!req0_valid)                          grant_chan = 1'b1;
    accept     = (state == IDLE) && !reset && (req0_valid || req1_valid);
    req0_ready = accept && !grant_chan;
    req1_ready = accept && grant_chan;
    grant_data = grant_chan ? req1_data : req0_data;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = DECODE;
      DECODE:  next_state = OUTPUT;
      OUTPUT:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign out_valid = (state == OUTPUT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cap_data  <= 8'h00;
      cap_chan  <= 1'b0;
      last_chan <= 1'b1;
      out_data  <= 8'h00;
      out_chan  <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cap_data <= grant_data;
        cap_chan <= grant_chan;
      end
      // Nibbles decode independently so a zero low nibble never borrows from the high one.
      if (state == DECODE) begin
        out_data <= {cap_data[7:4] - 4'd1, cap_data[3:0] - 4'd1};
        out_chan <= cap_chan;
      end
      if ((state == OUTPUT) && out_ready) last_chan <= out_chan;
    end
  end

`ifdef DECODE_ARBITER_ERRCNT_EN
  logic [1:0]      zero_cnt;
  logic [ERRW:0]   err_sum;
  logic [ERRW-1:0] err_reg;

  always_comb begin
    zero_cnt = {1'b0, grant_data[3:0] == 4'h0} + {1'b0, grant_data[7:4] == 4'h0};
    err_sum  = {1'b0, err_reg} + (ERRW+1)'(zero_cnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_reg <= '0;
    else if (accept) err_reg <= err_sum[ERRW] ? '1 : err_sum[ERRW-1:0];
  end

  assign err_cnt = err_reg;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_arbiter.sv
// Directed bench: round-robin instance (FAIR=1, ERRW=8) and fixed-priority instance (FAIR=0, ERRW=2).
module tb_decode_arbiter;

`ifdef DECODE_ARBITER_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data, out_data;
  logic       out_valid, out_chan, out_ready, busy;
  logic [7:0] err_cnt;

  logic       fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
  logic [7:0] fp_req0_data, fp_req1_data, fp_out_data;
  logic       fp_out_valid, fp_out_chan, fp_out_ready, fp_busy;
  logic [1:0] fp_err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;
  int exp_fp_err = 0;

  typedef struct {
    logic       chan;
    logic [7:0] data;
    logic [7:0] exp_data;
    int         zeros;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  decode_arbiter #(.FAIR(1), .ERRW(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready), .busy(busy), .err_cnt(err_cnt)
  );

  decode_arbiter #(.FAIR(0), .ERRW(2)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(fp_req0_valid), .req0_data(fp_req0_data), .req0_ready(fp_req0_ready),
    .req1_valid(fp_req1_valid), .req1_data(fp_req1_data), .req1_ready(fp_req1_ready),
    .out_valid(fp_out_valid), .out_data(fp_out_data), .out_chan(fp_out_chan),
    .out_ready(fp_out_ready), .busy(fp_busy), .err_cnt(fp_err_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_err = 0;
    exp_fp_err = 0;
    @(posedge clk);
    #1;
  endtask

  // One complete single-channel transfer on the round-robin instance with out_ready held high.
  task automatic applyStimulus(input logic chan, input logic [7:0] data, input logic [7:0] exp_data, input int zeros);
    int waited = 0;
    if (chan) begin req1_valid = 1'b1; req1_data = data; end
    else      begin req0_valid = 1'b1; req0_data = data; end
    @(negedge clk);
    while (!(chan ? req1_ready : req0_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("grant_ready", chan ? req1_ready : req0_ready, 1);
    checkOutput("other_ready", chan ? req0_ready : req1_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (ERR_EN) exp_err = (exp_err + zeros > 255) ? 255 : exp_err + zeros;
    @(negedge clk);
    checkOutput("decode_out_valid", out_valid, 0);
    checkOutput("decode_busy", busy, 1);
    @(negedge clk);
    checkOutput("out_valid", out_valid, 1);
    checkOutput("out_data", out_data, exp_data);
    checkOutput("out_chan", out_chan, chan);
    checkOutput("err_cnt", err_cnt, exp_err);
    @(posedge clk);
    #1;
    checkOutput("idle_busy", busy, 0);
  endtask

  task automatic fpTransfer(input logic [7:0] data, input logic [7:0] exp_data, input int zeros);
    fp_req0_valid = 1'b1;
    fp_req0_data  = data;
    @(negedge clk);
    checkOutput("fp_ready", fp_req0_ready, 1);
    @(posedge clk);
    #1;
    fp_req0_valid = 1'b0;
    if (ERR_EN) exp_fp_err = (exp_fp_err + zeros > 3) ? 3 : exp_fp_err + zeros;
    @(negedge clk);
    @(negedge clk);
    checkOutput("fp_out_valid", fp_out_valid, 1);
    checkOutput("fp_out_data", fp_out_data, exp_data);
    checkOutput("fp_err_cnt", fp_err_cnt, exp_fp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    int starved;
    vecs[0] = '{1'b0, 8'h5A, 8'h49, 0};
    vecs[1] = '{1'b1, 8'h22, 8'h11, 0};
    vecs[2] = '{1'b0, 8'h01, 8'hF0, 1};
    vecs[3] = '{1'b0, 8'h00, 8'hFF, 2};
    vecs[4] = '{1'b1, 8'h10, 8'h0F, 1};
    vecs[5] = '{1'b1, 8'hFF, 8'hEE, 0};
    vecs[6] = '{1'b0, 8'h81, 8'h70, 0};
    vecs[7] = '{1'b1, 8'h00, 8'hFF, 2};

    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h12; req1_data = 8'h34;
    out_ready = 1'b1;
    fp_req0_valid = 1'b0; fp_req1_valid = 1'b0; fp_req0_data = 8'h00; fp_req1_data = 8'h00;
    fp_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 8'h00);
    checkOutput("rst_out_chan", out_chan, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_req1_ready", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].chan, vecs[i].data, vecs[i].exp_data, vecs[i].zeros);

    // Contention on the round-robin instance: after reset ch0 first, then alternate.
    doReset();
    req0_valid = 1'b1; req0_data = 8'h22;
    req1_valid = 1'b1; req1_data = 8'h33;
    @(negedge clk);
    checkOutput("fair_first_req0", req0_ready, 1);
    checkOutput("fair_first_req1", req1_ready, 0);
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      @(negedge clk);
      while (!out_valid && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("fair_valid", out_valid, 1);
      checkOutput("fair_data", out_data, (k % 2 == 0) ? 8'h11 : 8'h22);
      checkOutput("fair_chan", out_chan, k % 2);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Fixed priority: ch1 never granted while ch0 stays valid.
    fp_req0_valid = 1'b1; fp_req0_data = 8'h22;
    fp_req1_valid = 1'b1; fp_req1_data = 8'h33;
    starved = 0;
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      @(negedge clk);
      if (fp_req1_ready) starved++;
      while (!fp_out_valid && waited < 10) begin
        @(negedge clk);
        if (fp_req1_ready) starved++;
        waited++;
      end
      checkOutput("fp_prio_data", fp_out_data, 8'h11);
      checkOutput("fp_prio_chan", fp_out_chan, 0);
      @(posedge clk);
      #1;
    end
    checkOutput("fp_req1_starved", starved, 0);
    fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;

    // Backpressure: OUTPUT held for 5 extra cycles while ch0 waits.
    doReset();
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h77;
    @(negedge clk);
    checkOutput("bp_req1_ready", req1_ready, 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h99;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_out_chan", out_chan, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_data", out_data, 8'h66);
      checkOutput("bp_hold_req0_ready", req0_ready, 0);
      checkOutput("bp_hold_req1_ready", req1_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_next_req0_ready", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_next_data", out_data, 8'h88);
    checkOutput("bp_next_chan", out_chan, 0);
    @(posedge clk);
    #1;

    // Reset while in DECODE: byte discarded, next grant goes to ch0 despite last served being 0.
    req1_valid = 1'b1; req1_data = 8'h44;
    @(negedge clk);
    checkOutput("rd_req1_ready", req1_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_data = 8'h66;
    @(negedge clk);
    checkOutput("rd_in_decode", busy, 1);
    reset = 1'b1;
    exp_err = 0;
    exp_fp_err = 0;
    #1;
    checkOutput("rd_out_valid", out_valid, 0);
    checkOutput("rd_busy", busy, 0);
    checkOutput("rd_out_data", out_data, 8'h00);
    checkOutput("rd_out_chan", out_chan, 0);
    checkOutput("rd_err_cnt", err_cnt, 0);
    checkOutput("rd_req0_ready", req0_ready, 0);
    checkOutput("rd_req1_ready", req1_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rd_first_req0", req0_ready, 1);
    checkOutput("rd_first_req1", req1_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rd_after_valid", out_valid, 1);
    checkOutput("rd_after_data", out_data, 8'h55);
    checkOutput("rd_after_chan", out_chan, 0);
    @(posedge clk);
    #1;

    // Saturation on the 2-bit counter: four all-zero bytes.
    for (int k = 0; k < 4; k++) fpTransfer(8'h00, 8'hFF, 2);
    repeat (3) @(negedge clk);
    checkOutput("fp_err_hold", fp_err_cnt, exp_fp_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
